// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the boot EEPROM link (controller and target side).
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    ADDR_ACK,
    WORD_ADDR,
    WORD_ACK,
    WRITE_DATA,
    WRITE_ACK,
    READ_DATA,
    READ_ACK
  } I2cTargetState;

  localparam logic [6:0] EEPROM_DEV_ADDR = 7'h50;
  localparam logic       I2C_WRITE       = 1'b0;
  localparam logic       I2C_READ        = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Input synchronizer with single-cycle rise/fall pulses on the synchronized level.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // No reset: a reset mid-transfer must not manufacture a false bus edge.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], d_i};
    prev_d  = sync_q[SYNC_STAGES-1];
    level_o = sync_q[SYNC_STAGES-1];
    rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

  always_ff @(posedge clk) begin
    sync_q <= sync_d;
    prev_q <= prev_d;
  end

endmodule

// File: rtl/i2c_eeprom_target.sv
// I2C target emulating a 256-byte serial EEPROM; SCL/SDA oversampled by clk,
// SDA driven open-drain through sda_oe.
module i2c_eeprom_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = EEPROM_DEV_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic       load_en,
  input  logic [7:0] load_addr,
  input  logic [7:0] load_data,
  output logic       busy,
  output logic [7:0] ptr
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .d_i(scl_i), .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall));
  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .d_i(sda_i), .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall));

  I2cTargetState state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic [7:0]    ptr_q, ptr_d;

  logic [7:0]    mem_q [256];
  logic          mem_we;
  logic [7:0]    mem_waddr, mem_wdata, rd_byte;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_waddr = load_addr;
    mem_wdata = load_data;
    rd_byte   = mem_q[ptr_q];

    if (load_en && !busy_q) mem_we = 1'b1;

    if (scl_lvl && sda_rise) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (scl_lvl && sda_fall) begin
      state_d = i2c_pkg::DEV_ADDR;
      cnt_d   = 4'd7;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        i2c_pkg::DEV_ADDR: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_lvl};
          cnt_d   = 4'(cnt_q - 4'd1);
          if (cnt_q == 4'd0) begin
            if (shift_q[6:0] == DEV_ADDR) begin
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        // oe_q doubles as the "ACK already driven" flag in the ACK states.
        ADDR_ACK: if (scl_fall) begin
          if (!oe_q) oe_d = 1'b1;
          else if (shift_q[0] == I2C_WRITE) begin
            oe_d    = 1'b0;
            cnt_d   = 4'd7;
            state_d = WORD_ADDR;
          end else begin
            oe_d    = ~rd_byte[7];
            shift_d = {rd_byte[6:0], 1'b0};
            cnt_d   = 4'd7;
            state_d = READ_DATA;
          end
        end
        WORD_ADDR: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_lvl};
          cnt_d   = 4'(cnt_q - 4'd1);
          if (cnt_q == 4'd0) state_d = WORD_ACK;
        end
        WORD_ACK: if (scl_fall) begin
          if (!oe_q) oe_d = 1'b1;
          else begin
            oe_d    = 1'b0;
            ptr_d   = shift_q;
            cnt_d   = 4'd7;
            state_d = WRITE_DATA;
          end
        end
        WRITE_DATA: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_lvl};
          cnt_d   = 4'(cnt_q - 4'd1);
          if (cnt_q == 4'd0) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = {shift_q[6:0], sda_lvl};
            ptr_d     = ptr_q + 8'd1;
            state_d   = WRITE_ACK;
          end
        end
        WRITE_ACK: if (scl_fall) begin
          if (!oe_q) oe_d = 1'b1;
          else begin
            oe_d    = 1'b0;
            cnt_d   = 4'd7;
            state_d = WRITE_DATA;
          end
        end
        READ_DATA: if (scl_fall) begin
          if (cnt_q == 4'd0) begin
            oe_d    = 1'b0;
            ptr_d   = ptr_q + 8'd1;
            state_d = READ_ACK;
          end else begin
            oe_d    = ~shift_q[7];
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = 4'(cnt_q - 4'd1);
          end
        end
        // After a controller ACK, the next SCL fall presents bit 7, hence cnt=8.
        READ_ACK: if (scl_rise) begin
          if (!sda_lvl) begin
            shift_d = rd_byte;
            cnt_d   = 4'd8;
            state_d = READ_DATA;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      shift_q <= 8'd0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      ptr_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign sda_oe = oe_q;
  assign busy   = busy_q;
  assign ptr    = ptr_q;

endmodule
